// File: rtl/vsq_scale_accum.sv
// vsq_scale_accum: multi-lane pipelined VSQ scale-and-accumulate.
// Stage 1 scales each lane's signed partial sum by a_scale[lane]*b_scale
// (or passes it through in plain mode). Stage 2 accumulates VEC_LEN beats
// per lane. The output register then holds each finished vector until the
// downstream valid/ready handshake completes.
// Optional build macro: VSQ_SAT_EN selects saturating accumulation and adds
// the per-lane sticky overflow port ovf_out. Without it, accumulation wraps.
module vsq_scale_accum #(
    parameter int LANES   = 4,
    parameter int PSUM_W  = 14,
    parameter int SCALE_W = 8,
    parameter int ACC_W   = 32,
    parameter int VEC_LEN = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       is_vsq,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*PSUM_W-1:0]    psum_in,
    input  logic [LANES*SCALE_W-1:0]   a_scale,
    input  logic [SCALE_W-1:0]         b_scale,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*ACC_W-1:0]     acc_out,
    output logic                       out_vsq
`ifdef VSQ_SAT_EN
    ,
    output logic [LANES-1:0]           ovf_out
`endif
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

`ifdef VSQ_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // Pipeline control
    logic                 en;
    logic                 accept;

    // Beat counter and per-vector mode
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 first_beat;
    logic                 last_beat;
    logic                 vsq_lat_q;
    logic                 vsq_eff;

    // Stage 1: scaled products
    logic [ACC_W-1:0]     prod_d [LANES];
    logic [ACC_W-1:0]     prod_q [LANES];
    logic                 s1_valid_q;
    logic                 s1_first_q;
    logic                 s1_last_q;
    logic                 s1_vsq_q;

    // Stage 2: accumulators
    logic [ACC_W-1:0]     acc_d [LANES];
    logic [ACC_W-1:0]     acc_q [LANES];
    logic                 acc_done_q;
    logic                 acc_vsq_q;

    // Output holding register
    logic                 out_valid_q;
    logic                 out_vsq_q;
    logic [LANES*ACC_W-1:0] acc_out_q;

`ifdef VSQ_SAT_EN
    logic [LANES-1:0]     ovf_d;
    logic [LANES-1:0]     ovf_q;
    logic [LANES-1:0]     ovf_out_q;
`endif

    // The whole pipeline freezes while a finished vector waits for out_ready
    assign en        = !(out_valid_q && !out_ready);
    assign accept    = in_valid && en;
    assign in_ready  = en;

    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == LAST_BEAT);
    assign cnt_d      = last_beat ? '0 : cnt_q + 1'b1;
    // Mode is taken live on beat 0 and from the latch for the rest of the vector
    assign vsq_eff    = first_beat ? is_vsq : vsq_lat_q;

    // Per-lane scale: sign-extended psum times zero-extended full-precision scale product
    always_comb begin
        logic signed [ACC_W-1:0]   psum_ext;
        logic signed [ACC_W-1:0]   scale_ext;
        logic [2*SCALE_W-1:0]      scale_prod;
        psum_ext   = '0;
        scale_ext  = '0;
        scale_prod = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            psum_ext   = ACC_W'($signed(psum_in[i*PSUM_W +: PSUM_W]));
            scale_prod = a_scale[i*SCALE_W +: SCALE_W] * b_scale;
            scale_ext  = ACC_W'(scale_prod);
            prod_d[i]  = vsq_eff ? psum_ext * scale_ext : psum_ext;
        end
    end

    // Stage 1 register, beat counter and mode latch advance on accepted beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            vsq_lat_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_vsq_q   <= 1'b0;
            prod_q     <= '{default: '0};
        end else if (en) begin
            s1_valid_q <= accept;
            if (accept) begin
                prod_q     <= prod_d;
                s1_first_q <= first_beat;
                s1_last_q  <= last_beat;
                s1_vsq_q   <= vsq_eff;
                vsq_lat_q  <= vsq_eff;
                cnt_q      <= cnt_d;
            end
        end
    end

`ifdef VSQ_SAT_EN
    // Saturating accumulate: the first beat loads, later beats clamp on signed overflow
    always_comb begin
        logic [ACC_W:0] sum;
        sum   = '0;
        ovf_d = ovf_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum = {acc_q[i][ACC_W-1], acc_q[i]} + {prod_q[i][ACC_W-1], prod_q[i]};
            if (s1_first_q) begin
                acc_d[i] = prod_q[i];
                ovf_d[i] = 1'b0;
            end else if (sum[ACC_W] != sum[ACC_W-1]) begin
                acc_d[i] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                ovf_d[i] = 1'b1;
            end else begin
                acc_d[i] = sum[ACC_W-1:0];
            end
        end
    end
`else
    // Wrapping accumulate: the first beat loads, later beats add mod 2^ACC_W
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            acc_d[i] = s1_first_q ? prod_q[i] : acc_q[i] + prod_q[i];
        end
    end
`endif

    // Stage 2 register: accumulators plus a done flag for the last beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q      <= '{default: '0};
            acc_done_q <= 1'b0;
            acc_vsq_q  <= 1'b0;
`ifdef VSQ_SAT_EN
            ovf_q      <= '0;
`endif
        end else if (en) begin
            acc_done_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                acc_q     <= acc_d;
                acc_vsq_q <= s1_vsq_q;
`ifdef VSQ_SAT_EN
                ovf_q     <= ovf_d;
`endif
            end
        end
    end

    // Output register: loads a finished vector, clears valid after a plain handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_vsq_q   <= 1'b0;
            acc_out_q   <= '0;
`ifdef VSQ_SAT_EN
            ovf_out_q   <= '0;
`endif
        end else if (en) begin
            out_valid_q <= acc_done_q;
            if (acc_done_q) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    acc_out_q[i*ACC_W +: ACC_W] <= acc_q[i];
                end
                out_vsq_q <= acc_vsq_q;
`ifdef VSQ_SAT_EN
                ovf_out_q <= ovf_q;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_vsq   = out_vsq_q;
    assign acc_out   = acc_out_q;
`ifdef VSQ_SAT_EN
    assign ovf_out   = ovf_out_q;
`endif

endmodule
